// File: rtl/fifo_out.sv
// Keeps the leading KEEP_POINT samples of each NFFT-point FFT frame, packs sample
// pairs into 32-bit words and queues them in a circular buffer for a ready/valid sink.
module fifo_out #(
  parameter int NFFT       = 64,
  parameter int KEEP_POINT = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           data_in,
  input  logic                  data_valid,
  input  logic                  out_ready,
  output logic [31:0]           data_out,
  output logic                  out_valid,
  output logic [DEPTH_LOG2:0]   word_count,
  output logic                  frame_done,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int PW = (NFFT > 2) ? $clog2(NFFT) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0] LAST_PT = PW'(NFFT - 1);
  localparam logic [PW-1:0] KEEP_LAST = PW'(KEEP_POINT - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, KEEP, DISCARD} state_t;

  state_t                state_q;
  logic [PW-1:0]         pt_cnt_q;
  logic [15:0]           held_q;
  logic                  frame_done_q;
  logic                  frame_err_q;
  logic                  overflow_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [31:0]           mem [DEPTH];

  logic push, pop, full, wr_en;
  logic [31:0] word_in;

  always_comb begin
    push    = data_valid && (state_q == KEEP) && pt_cnt_q[0];
    word_in = {held_q, data_in};
    full    = (count_q == FULL_CNT);
    pop     = (count_q != '0) && out_ready;
    wr_en   = push && (!full || pop);
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame tracking: IDLE and KEEP-at-point-0 treat a valid sample identically,
  // the difference is only that a gap in KEEP at point 0 is a clean frame boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pt_cnt_q     <= '0;
      held_q       <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (data_valid) begin
            held_q   <= data_in;
            pt_cnt_q <= PW'(1);
            state_q  <= KEEP;
          end
        end
        KEEP, DISCARD: begin
          if (data_valid) begin
            if (state_q == KEEP && !pt_cnt_q[0]) held_q <= data_in;
            if (pt_cnt_q == LAST_PT) begin
              pt_cnt_q     <= '0;
              frame_done_q <= 1'b1;
              state_q      <= KEEP;
            end else begin
              pt_cnt_q <= pt_cnt_q + PW'(1);
              if (state_q == KEEP && pt_cnt_q == KEEP_LAST) state_q <= DISCARD;
            end
          end else begin
            if (pt_cnt_q != '0) frame_err_q <= 1'b1;
            pt_cnt_q <= '0;
            held_q   <= '0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      if (push && full && !pop) overflow_q <= 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem[wr_ptr_q] <= word_in;
  end

  assign data_out   = mem[rd_ptr_q];
  assign out_valid  = (count_q != '0);
  assign word_count = count_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fifo_out.sv
// Scoreboard bench for fifo_out: two instances (KEEP_POINT 4 and 8) share stimulus,
// a frame-position reference model queues expected words, a negedge monitor checks them.
module tb_fifo_out;
  localparam int NFFT  = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dataIn = '0;
  logic        dataValid = 1'b0;
  logic        outReady = 1'b0;

  logic [1:0][31:0] dataOut;
  logic [1:0]       outValid, frameDone, overflow, frameErr;
  logic [1:0][2:0]  wordCount;

  int compared = 0;
  int mismatched = 0;
  bit checkEn = 0;

  int          mIdx[2], mCount[2];
  logic [15:0] mHeld[2];
  bit          mOvf[2], mErr[2], mDone[2];
  logic [31:0] expQA[$], expQB[$];

  always #5 clk = ~clk;

  fifo_out #(.NFFT(8), .KEEP_POINT(4), .DEPTH_LOG2(2)) dutA (
    .clk(clk), .rst(rst), .data_in(dataIn), .data_valid(dataValid), .out_ready(outReady),
    .data_out(dataOut[0]), .out_valid(outValid[0]), .word_count(wordCount[0]),
    .frame_done(frameDone[0]), .overflow(overflow[0]), .frame_err(frameErr[0]));

  fifo_out #(.NFFT(8), .KEEP_POINT(8), .DEPTH_LOG2(2)) dutB (
    .clk(clk), .rst(rst), .data_in(dataIn), .data_valid(dataValid), .out_ready(outReady),
    .data_out(dataOut[1]), .out_valid(outValid[1]), .word_count(wordCount[1]),
    .frame_done(frameDone[1]), .overflow(overflow[1]), .frame_err(frameErr[1]));

  function automatic int keepOf(input int i);
    return (i == 0) ? 4 : 8;
  endfunction

  // Reference model: position within frame, which positions are kept, and buffer occupancy.
  task automatic modelStep(input int i);
    bit push;
    bit pop;
    logic [31:0] w;
    push = 0;
    w = '0;
    if (!rst) begin
      mIdx[i] = 0; mCount[i] = 0; mHeld[i] = '0;
      mOvf[i] = 0; mErr[i] = 0; mDone[i] = 0;
      if (i == 0) expQA.delete(); else expQB.delete();
    end else begin
      mDone[i] = 0;
      pop = (mCount[i] > 0) && outReady;
      if (dataValid) begin
        if (mIdx[i] < keepOf(i)) begin
          if (mIdx[i] % 2 == 0) mHeld[i] = dataIn;
          else begin
            push = 1;
            w = {mHeld[i], dataIn};
          end
        end
        if (mIdx[i] == NFFT - 1) begin
          mIdx[i] = 0;
          mDone[i] = 1;
        end else mIdx[i]++;
      end else if (mIdx[i] != 0) begin
        mErr[i] = 1;
        mIdx[i] = 0;
      end
      if (pop) mCount[i]--;
      if (push) begin
        if (mCount[i] == DEPTH) mOvf[i] = 1;
        else begin
          mCount[i]++;
          if (i == 0) expQA.push_back(w); else expQB.push_back(w);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) modelStep(i);
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s inst%0d: got 0x%08h, expected 0x%08h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic monitorInst(input int i);
    logic [31:0] e;
    checkOutput("out_valid", i, 32'(outValid[i]), 32'(mCount[i] != 0));
    checkOutput("word_count", i, 32'(wordCount[i]), 32'(mCount[i]));
    checkOutput("frame_done", i, 32'(frameDone[i]), 32'(mDone[i]));
    checkOutput("overflow", i, 32'(overflow[i]), 32'(mOvf[i]));
    checkOutput("frame_err", i, 32'(frameErr[i]), 32'(mErr[i]));
    if (outValid[i] && outReady) begin
      if ((i == 0 ? expQA.size() : expQB.size()) == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL data_out inst%0d: got 0x%08h, expected no word at %0t", i, dataOut[i], $time);
      end else begin
        e = (i == 0) ? expQA.pop_front() : expQB.pop_front();
        checkOutput("data_out", i, dataOut[i], e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) for (int i = 0; i < 2; i++) monitorInst(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dataValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic applyStimulus(input logic [15:0] base, input int nPoints, input bit randMode);
    for (int p = 0; p < nPoints; p++) begin
      dataValid = 1'b1;
      dataIn = randMode ? 16'($urandom) : base + 16'(p);
      if (randMode) outReady = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    tick();
    checkEn = 1;
    tick();
    rst = 1'b1;

    outReady = 1'b1;
    applyStimulus(16'h0001, 8, 0);
    idle(3);

    // Three back-to-back frames into a stalled sink, then drain.
    outReady = 1'b0;
    applyStimulus(16'h0101, 8, 0);
    applyStimulus(16'h0111, 8, 0);
    applyStimulus(16'h0121, 8, 0);
    idle(3);
    outReady = 1'b1;
    idle(8);

    applyStimulus(16'h0021, 6, 0);
    idle(2);
    applyStimulus(16'h0011, 8, 0);
    idle(4);

    // Fill the buffer, then pop exactly on the cycle of the next push.
    outReady = 1'b0;
    applyStimulus(16'h0201, 8, 0);
    applyStimulus(16'h0211, 8, 0);
    for (int p = 0; p < 8; p++) begin
      outReady = (p == 1);
      dataValid = 1'b1;
      dataIn = 16'h0301 + 16'(p);
      tick();
    end
    outReady = 1'b1;
    idle(8);

    outReady = 1'b0;
    applyStimulus(16'h0401, 8, 0);
    applyStimulus(16'h0501, 2, 0);
    rst = 1'b0;
    dataIn = 16'hBEEF;
    dataValid = 1'b1;
    outReady = 1'b1;
    tick();
    rst = 1'b1;
    idle(1);
    applyStimulus(16'h0601, 8, 0);
    idle(6);

    for (int f = 0; f < 40; f++) begin
      int len;
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
      applyStimulus(16'h0000, len, 1);
      if (len != 8 || $urandom_range(0, 1) == 1) begin
        dataValid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          outReady = 1'($urandom_range(0, 1));
          tick();
        end
      end
    end

    outReady = 1'b1;
    idle(12);
    checkOutput("drain_empty", 0, 32'(expQA.size()), 32'd0);
    checkOutput("drain_empty", 1, 32'(expQB.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
